nn_sequencer: RTL and testbench
===============================

Name: nn_sequencer

Overview:
Registered, self-counting successor to the combinational layer/cost controller. It accepts op codes over a valid/ready handshake and generates its own row and layer counters internally. It drives the weight-storage, systolic-array and backpropagator control strobes. Generalised over row size and layer count, and adds a pause-capable enable, an epoch counter and error reporting. Sits between the code-line fetch unit and the datapath.

Parameters:
OP_SIZE, 4, op code width
ROW_SIZE, 3, systolic rows per layer (R); must be ≥1
MAX_LAYERS, 4, number of weight layers; legal layer_index range is 0..MAX_LAYERS-1
IDX_W, 32, width of index outputs
EPOCH_W, 16, width of epoch_size and epoch_count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  run enable; low pauses the sequencer
op  in  OP_SIZE  op code
op_valid  in  1  op and layer_index are valid
op_ready  out  1  sequencer can accept an op
layer_index  in  IDX_W  target layer; sampled at accept
epoch_size  in  EPOCH_W  ops per epoch; sampled at each OP_END_EPOCH
w_layer_index  out  IDX_W  layer index for load/backprop
w_row_index  out  IDX_W  row index for load/backprop
is_load  out  1  read weight storage
is_update  out  1  advance backpropagator
i_is_load  out  1  fetch next input data set
load_w  out  1  write weights into systolic array
backprop_cost  out  1  backprop cost and update dc/dw
use_z  out  1  feed z as data set
is_cost_layer  out  1  dc/dw computation phase
op_done  out  1  one-cycle pulse at op completion
op_error  out  1  one-cycle pulse on a rejected op
busy  out  1  sequencer is not in IDLE
epoch_count  out  EPOCH_W  completed END_EPOCH ops in the current epoch
epoch_done  out  1  one-cycle pulse when an epoch wraps

Behaviour:
- Clock and reset: single clock, synchronous active-high reset.
- Reset values: all outputs are 0 except op_ready=1. State is IDLE and counters are 0. A reset mid-op aborts the op with no op_done.
- Op codes: OP_NOP=0, OP_SET_LAYER=1, OP_SET_COST=2, OP_END_EPOCH=3.
- States: IDLE, LOAD_W, FORWARD, DRAIN, COST_WAIT, COST_BP, DCDW, DONE, ERR.
- Output timing: all outputs are registered. The op is accepted in cycle T when op_valid && op_ready. The first sequenced output appears at T+1.
- op_ready: 1 only in IDLE with enable=1. busy = !IDLE.
- Accept decode:
  - SET_LAYER or SET_COST with layer_index ≥ MAX_LAYERS → ERR.
  - Any op code outside 1..3 → ERR.
  - ERR lasts 1 cycle with op_error=1, then IDLE.
  - OP_NOP is accepted and ignored.
- Row counter rc runs 0..R-1 in each phase. w_row_index = rc. Zero-extend all indices to IDX_W.
- SET_LAYER (layer L latched at accept):
  - LOAD_W, R cycles: load_w=1, is_load=1, w_layer_index=L.
  - FORWARD, R cycles: is_load=1, is_update=1, w_layer_index=L. If L==0 then i_is_load=1; otherwise use_z=1.
  - DRAIN, R cycles: all strobes 0, indices 0.
  - DONE, 1 cycle: op_done=1, then IDLE.
  - op_done occurs at T+3R+1.
- SET_COST (layer L latched at accept):
  - COST_WAIT, R cycles: all strobes 0.
  - COST_BP, R cycles: backprop_cost=1, use_z=1, is_update=1, w_layer_index=L.
  - DCDW, L·R cycles: is_cost_layer=1, is_update=1. w_layer_index ascends 0..L-1 and w_row_index runs 0..R-1 within each layer. DCDW is skipped when L==0.
  - DONE: op_done at T+(2+L)R+1.
- OP_END_EPOCH: goes straight to DONE at T+1.
  - In that cycle epoch_count increments.
  - If the incremented value ≥ epoch_size, epoch_count becomes 0 and epoch_done=1.
  - epoch_size=0 is treated as 1.
- enable=0 outside IDLE: state, counters and latched L freeze. All strobes (is_load, is_update, i_is_load, load_w, backprop_cost, use_z, is_cost_layer, op_done, op_error) are forced to 0. Index outputs hold their values. The sequence resumes exactly on re-enable, so every phase boundary shifts by the number of paused cycles.
- enable=0 in IDLE: op_ready=0 and no accept.
- Back-to-back ops: the earliest next accept is the cycle after DONE/ERR. There is no pipelining of ops.

Decomposition:
- Shared package nn_pkg: op code localparams, state enum typedef, a phase-length helper function.
- One natural sub-module: nn_row_layer_counter. It is a row/layer counter with clear, enable and terminal flags (last_row, last_layer), parametrised by ROW_SIZE and MAX_LAYERS.

Test Plan (R=3, MAX_LAYERS=4):
- SET_LAYER L=0 accepted at T=0:
  - cycles 1-3: load_w=1, rows 0,1,2.
  - cycles 4-6: i_is_load=1, is_update=1, rows 0-2.
  - cycles 7-9: all strobes 0.
  - cycle 10: op_done; op_ready=1 at cycle 11.
- SET_LAYER L=2: cycles 4-6 have use_z=1, i_is_load=0, w_layer_index=2.
- SET_COST L=2 at T=0:
  - cycles 1-3: all strobes 0.
  - cycles 4-6: backprop_cost=1, use_z=1, layer 2.
  - cycles 7-12: is_cost_layer=1, layers 0,0,0,1,1,1 with rows 0,1,2,0,1,2.
  - cycle 13: op_done.
- SET_LAYER L=0 with enable low in cycles 5-6: strobes are 0 in those cycles, rows resume at 1, op_done at cycle 12.
- epoch_size=2, three END_EPOCH ops → epoch_count 1, 0 (epoch_done pulse), 1.
- SET_COST L=4 → op_error at T+1 and no strobes. Separately, reset asserted at cycle 5 of a SET_LAYER → all outputs 0 and op_ready=1 the next cycle, with no op_done.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network sequencer: op codes, FSM states
// and phase-length arithmetic.
package nn_pkg;
  localparam int OP_NOP       = 0;
  localparam int OP_SET_LAYER = 1;
  localparam int OP_SET_COST  = 2;
  localparam int OP_END_EPOCH = 3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD_W, ST_FORWARD, ST_DRAIN, ST_COST_WAIT,
    ST_COST_BP, ST_DCDW, ST_DONE, ST_ERR
  } state_t;

  // Cycles spent in a phase for target layer l with r systolic rows.
  function automatic int unsigned phase_len(state_t s, int unsigned l, int unsigned r);
    case (s)
      ST_LOAD_W, ST_FORWARD, ST_DRAIN, ST_COST_WAIT, ST_COST_BP: return r;
      ST_DCDW:         return l * r;
      ST_DONE, ST_ERR: return 1;
      default:         return 0;
    endcase
  endfunction
endpackage

// File: rtl/nn_row_layer_counter.sv
// Row/layer counter: rows wrap 0..ROW_SIZE-1 and carry into the layer count.
// Exposes next-cycle values so the sequencer can register its outputs.
module nn_row_layer_counter #(
  parameter int ROW_SIZE   = 3,
  parameter int MAX_LAYERS = 4,
  localparam int RW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1,
  localparam int LW = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [LW-1:0] i_last_layer,
  output logic [RW-1:0] o_row_nxt,
  output logic [LW-1:0] o_layer_nxt,
  output logic          o_last_row,
  output logic          o_last_layer
);
  logic [RW-1:0] r_row;
  logic [LW-1:0] r_layer;

  assign o_last_row   = (r_row == RW'(ROW_SIZE - 1));
  assign o_last_layer = (r_layer == i_last_layer);

  always_comb begin
    o_row_nxt   = r_row;
    o_layer_nxt = r_layer;
    if (i_clr) begin
      o_row_nxt   = '0;
      o_layer_nxt = '0;
    end else if (i_en) begin
      if (o_last_row) begin
        o_row_nxt   = '0;
        o_layer_nxt = r_layer + LW'(1);
      end else begin
        o_row_nxt = r_row + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row   <= '0;
      r_layer <= '0;
    end else begin
      r_row   <= o_row_nxt;
      r_layer <= o_layer_nxt;
    end
  end
endmodule

// File: rtl/nn_sequencer.sv
// Registered layer/cost sequencer: accepts ops over valid/ready and walks the
// load, forward, drain, cost and dc/dw phases with its own row/layer counters.
module nn_sequencer
  import nn_pkg::*;
#(
  parameter int OP_SIZE    = 4,
  parameter int ROW_SIZE   = 3,
  parameter int MAX_LAYERS = 4,
  parameter int IDX_W      = 32,
  parameter int EPOCH_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [OP_SIZE-1:0] op,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [IDX_W-1:0]   layer_index,
  input  logic [EPOCH_W-1:0] epoch_size,
  output logic [IDX_W-1:0]   w_layer_index,
  output logic [IDX_W-1:0]   w_row_index,
  output logic               is_load,
  output logic               is_update,
  output logic               i_is_load,
  output logic               load_w,
  output logic               backprop_cost,
  output logic               use_z,
  output logic               is_cost_layer,
  output logic               op_done,
  output logic               op_error,
  output logic               busy,
  output logic [EPOCH_W-1:0] epoch_count,
  output logic               epoch_done
);
  localparam int RW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int LW = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;

  state_t             r_state, w_state_n;
  logic [LW-1:0]      r_l, w_l_n, w_last_layer, w_layer_nxt;
  logic [RW-1:0]      w_row_nxt;
  logic               w_accept, w_layer_ok, w_clr, w_step, w_last_row, w_last_layer_hit;
  logic               w_wrap;
  logic [EPOCH_W:0]   w_inc, w_sz;
  logic [EPOCH_W-1:0] w_epoch_n;
  logic               w_is_load, w_is_update, w_i_is_load, w_load_w, w_bp, w_use_z;
  logic               w_cost, w_done, w_err;
  logic [IDX_W-1:0]   w_wl, w_wr;

  assign w_layer_ok   = (layer_index < IDX_W'(MAX_LAYERS));
  assign w_accept     = (r_state == ST_IDLE) && op_ready && enable && op_valid;
  assign w_last_layer = r_l - LW'(1);
  assign w_inc        = {1'b0, epoch_count} + (EPOCH_W + 1)'(1);
  assign w_sz         = (epoch_size == '0) ? (EPOCH_W + 1)'(1) : {1'b0, epoch_size};

  nn_row_layer_counter #(.ROW_SIZE(ROW_SIZE), .MAX_LAYERS(MAX_LAYERS)) u_cnt (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_clr),
    .i_en         (w_step),
    .i_last_layer (w_last_layer),
    .o_row_nxt    (w_row_nxt),
    .o_layer_nxt  (w_layer_nxt),
    .o_last_row   (w_last_row),
    .o_last_layer (w_last_layer_hit)
  );

  always_comb begin : next_state
    w_state_n = r_state;
    w_l_n     = r_l;
    w_clr     = 1'b0;
    w_step    = 1'b0;
    w_wrap    = 1'b0;
    w_epoch_n = epoch_count;
    if (r_state == ST_IDLE) begin
      if (w_accept) begin
        w_clr = 1'b1;
        if (op == OP_SIZE'(OP_SET_LAYER) || op == OP_SIZE'(OP_SET_COST)) begin
          if (w_layer_ok) begin
            w_l_n     = layer_index[LW-1:0];
            w_state_n = (op == OP_SIZE'(OP_SET_LAYER)) ? ST_LOAD_W : ST_COST_WAIT;
          end else begin
            w_state_n = ST_ERR;
          end
        end else if (op == OP_SIZE'(OP_END_EPOCH)) begin
          w_state_n = ST_DONE;
          w_wrap    = (w_inc >= w_sz);
          w_epoch_n = w_wrap ? '0 : w_inc[EPOCH_W-1:0];
        end else if (op != OP_SIZE'(OP_NOP)) begin
          w_state_n = ST_ERR;
        end
      end
    end else if (enable) begin
      // a low enable leaves state, counters and the latched layer untouched
      unique case (r_state)
        ST_LOAD_W:    if (w_last_row) begin w_state_n = ST_FORWARD; w_clr = 1'b1; end else w_step = 1'b1;
        ST_FORWARD:   if (w_last_row) begin w_state_n = ST_DRAIN;   w_clr = 1'b1; end else w_step = 1'b1;
        ST_DRAIN:     if (w_last_row) w_state_n = ST_DONE; else w_step = 1'b1;
        ST_COST_WAIT: if (w_last_row) begin w_state_n = ST_COST_BP; w_clr = 1'b1; end else w_step = 1'b1;
        ST_COST_BP: begin
          if (w_last_row) begin
            w_clr     = 1'b1;
            w_state_n = (phase_len(ST_DCDW, 32'(r_l), ROW_SIZE) == 0) ? ST_DONE : ST_DCDW;
          end else begin
            w_step = 1'b1;
          end
        end
        ST_DCDW:      if (w_last_row && w_last_layer_hit) w_state_n = ST_DONE; else w_step = 1'b1;
        default:      w_state_n = ST_IDLE;
      endcase
    end
  end

  // Decode the outputs of the slot being entered so they can be registered.
  always_comb begin : decode
    w_is_load   = 1'b0;
    w_is_update = 1'b0;
    w_i_is_load = 1'b0;
    w_load_w    = 1'b0;
    w_bp        = 1'b0;
    w_use_z     = 1'b0;
    w_cost      = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_wl        = '0;
    w_wr        = '0;
    unique case (w_state_n)
      ST_LOAD_W: begin
        w_load_w  = 1'b1;
        w_is_load = 1'b1;
        w_wl      = IDX_W'(w_l_n);
        w_wr      = IDX_W'(w_row_nxt);
      end
      ST_FORWARD: begin
        w_is_load   = 1'b1;
        w_is_update = 1'b1;
        w_i_is_load = (w_l_n == '0);
        w_use_z     = (w_l_n != '0);
        w_wl        = IDX_W'(w_l_n);
        w_wr        = IDX_W'(w_row_nxt);
      end
      ST_COST_BP: begin
        w_bp        = 1'b1;
        w_use_z     = 1'b1;
        w_is_update = 1'b1;
        w_wl        = IDX_W'(w_l_n);
        w_wr        = IDX_W'(w_row_nxt);
      end
      ST_DCDW: begin
        w_cost      = 1'b1;
        w_is_update = 1'b1;
        w_wl        = IDX_W'(w_layer_nxt);
        w_wr        = IDX_W'(w_row_nxt);
      end
      ST_DONE: w_done = 1'b1;
      ST_ERR:  w_err  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_l           <= '0;
      op_ready      <= 1'b1;
      busy          <= 1'b0;
      w_layer_index <= '0;
      w_row_index   <= '0;
      is_load       <= 1'b0;
      is_update     <= 1'b0;
      i_is_load     <= 1'b0;
      load_w        <= 1'b0;
      backprop_cost <= 1'b0;
      use_z         <= 1'b0;
      is_cost_layer <= 1'b0;
      op_done       <= 1'b0;
      op_error      <= 1'b0;
      epoch_count   <= '0;
      epoch_done    <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_l           <= w_l_n;
      op_ready      <= (w_state_n == ST_IDLE) && enable;
      busy          <= (w_state_n != ST_IDLE);
      w_layer_index <= w_wl;
      w_row_index   <= w_wr;
      is_load       <= w_is_load   && enable;
      is_update     <= w_is_update && enable;
      i_is_load     <= w_i_is_load && enable;
      load_w        <= w_load_w    && enable;
      backprop_cost <= w_bp        && enable;
      use_z         <= w_use_z     && enable;
      is_cost_layer <= w_cost      && enable;
      op_done       <= w_done      && enable;
      op_error      <= w_err       && enable;
      epoch_count   <= w_epoch_n;
      epoch_done    <= w_wrap;
    end
  end
endmodule

// File: tb/tb_nn_sequencer.sv
// Scoreboard bench for nn_sequencer: a slot-list reference model queues the
// expected output word for every cycle and a monitor compares on each negedge.
module tb_nn_sequencer;
  localparam int R    = 3;
  localparam int MAXL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  op = '0;
  logic        op_valid = 1'b0;
  logic [31:0] layer_index = '0;
  logic [15:0] epoch_size = '0;
  logic        op_ready, is_load, is_update, i_is_load, load_w, backprop_cost, use_z;
  logic        is_cost_layer, op_done, op_error, busy, epoch_done;
  logic [31:0] w_layer_index, w_row_index;
  logic [15:0] epoch_count;

  typedef struct packed {
    logic op_ready; logic busy; logic is_load; logic is_update; logic i_is_load; logic load_w;
    logic backprop_cost; logic use_z; logic is_cost_layer; logic op_done; logic op_error;
    logic epoch_done; logic [15:0] epoch_count; logic [31:0] wl; logic [31:0] wr;
  } exp_t;

  exp_t expq[$];
  exp_t slots[$];
  exp_t cur;
  exp_t got;
  int   k = 0;
  bit   m_idle = 1'b1;
  int   m_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  nn_sequencer #(.OP_SIZE(4), .ROW_SIZE(R), .MAX_LAYERS(MAXL), .IDX_W(32), .EPOCH_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .op(op), .op_valid(op_valid),
    .op_ready(op_ready), .layer_index(layer_index), .epoch_size(epoch_size),
    .w_layer_index(w_layer_index), .w_row_index(w_row_index), .is_load(is_load),
    .is_update(is_update), .i_is_load(i_is_load), .load_w(load_w),
    .backprop_cost(backprop_cost), .use_z(use_z), .is_cost_layer(is_cost_layer),
    .op_done(op_done), .op_error(op_error), .busy(busy), .epoch_count(epoch_count),
    .epoch_done(epoch_done)
  );

  assign got = {op_ready, busy, is_load, is_update, i_is_load, load_w, backprop_cost, use_z,
                is_cost_layer, op_done, op_error, epoch_done, epoch_count, w_layer_index, w_row_index};

  function automatic exp_t idle_e(input logic en);
    exp_t e;
    e = '0;
    e.op_ready = en;
    e.epoch_count = 16'(m_cnt);
    return e;
  endfunction

  function automatic exp_t base();
    exp_t e;
    e = '0;
    e.busy = 1'b1;
    e.epoch_count = 16'(m_cnt);
    return e;
  endfunction

  // Expected per-cycle slots for one accepted op, straight from the op rules.
  task automatic build(input logic [3:0] o, input logic [31:0] li, input logic [15:0] es);
    exp_t s;
    int   sz;
    int   L;
    slots.delete();
    if (o == 4'd0) return;
    if (o > 4'd3 || (o != 4'd3 && li >= MAXL)) begin
      s = base(); s.op_error = 1'b1; slots.push_back(s);
      return;
    end
    if (o == 4'd3) begin
      sz = (es == 16'd0) ? 1 : int'(es);
      s = base();
      m_cnt++;
      if (m_cnt >= sz) begin m_cnt = 0; s.epoch_done = 1'b1; end
      s.epoch_count = 16'(m_cnt);
      s.op_done = 1'b1;
      slots.push_back(s);
      return;
    end
    L = int'(li);
    if (o == 4'd1) begin
      for (int r = 0; r < R; r++) begin
        s = base(); s.load_w = 1'b1; s.is_load = 1'b1; s.wl = 32'(L); s.wr = 32'(r); slots.push_back(s);
      end
      for (int r = 0; r < R; r++) begin
        s = base(); s.is_load = 1'b1; s.is_update = 1'b1; s.i_is_load = (L == 0); s.use_z = (L != 0);
        s.wl = 32'(L); s.wr = 32'(r); slots.push_back(s);
      end
      for (int r = 0; r < R; r++) slots.push_back(base());
    end else begin
      for (int r = 0; r < R; r++) slots.push_back(base());
      for (int r = 0; r < R; r++) begin
        s = base(); s.backprop_cost = 1'b1; s.use_z = 1'b1; s.is_update = 1'b1;
        s.wl = 32'(L); s.wr = 32'(r); slots.push_back(s);
      end
      for (int l = 0; l < L; l++)
        for (int r = 0; r < R; r++) begin
          s = base(); s.is_cost_layer = 1'b1; s.is_update = 1'b1; s.wl = 32'(l); s.wr = 32'(r);
          slots.push_back(s);
        end
    end
    s = base(); s.op_done = 1'b1; slots.push_back(s);
  endtask

  task automatic model_step(input logic rst_i, en_i, vld_i, input logic [3:0] op_i,
                            input logic [31:0] li, input logic [15:0] es_i);
    if (rst_i) begin
      m_idle = 1'b1; m_cnt = 0; slots.delete(); cur = idle_e(1'b1);
      return;
    end
    if (m_idle) begin
      if (vld_i && en_i && cur.op_ready) begin
        build(op_i, li, es_i);
        if (slots.size() > 0) begin m_idle = 1'b0; k = 0; cur = slots[0]; end
        else cur = idle_e(en_i);
      end else begin
        cur = idle_e(en_i);
      end
    end else if (en_i) begin
      k++;
      if (k >= slots.size()) begin m_idle = 1'b1; cur = idle_e(1'b1); end
      else cur = slots[k];
    end else begin
      cur.is_load = 0; cur.is_update = 0; cur.i_is_load = 0; cur.load_w = 0;
      cur.backprop_cost = 0; cur.use_z = 0; cur.is_cost_layer = 0; cur.op_done = 0;
      cur.op_error = 0; cur.epoch_done = 0; cur.op_ready = 0; cur.busy = 1;
    end
  endtask

  task automatic tick(input logic rst_i, en_i, vld_i, input logic [3:0] op_i,
                      input logic [31:0] li, input logic [15:0] es_i);
    reset = rst_i; enable = en_i; op_valid = vld_i; op = op_i;
    layer_index = li; epoch_size = es_i;
    @(posedge clk); #1;
    model_step(rst_i, en_i, vld_i, op_i, li, es_i);
    expq.push_back(cur);
  endtask

  // Cycle n counts from 1 = first cycle after the accept edge.
  task automatic run_op(input logic [3:0] o, input logic [31:0] li, input logic [15:0] es,
                        input int p_lo, input int p_hi, input int rst_at, input bit rnd_pause);
    int   guard;
    int   n;
    logic en;
    guard = 0;
    while (!cur.op_ready && guard < 10) begin tick(1'b0, 1'b1, 1'b0, 4'd0, 32'd0, es); guard++; end
    tick(1'b0, 1'b1, 1'b1, o, li, es);
    n = 1;
    while (!m_idle && n < 200) begin
      n++;
      en = !(n >= p_lo && n <= p_hi);
      if (rnd_pause && $urandom_range(0, 4) == 0) en = 1'b0;
      tick(n == rst_at, en, 1'b0, 4'd0, 32'd0, es);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        n_tests++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL cycle %0d outputs: got flags=%b ecnt=%0d layer=%0d row=%0d, expected flags=%b ecnt=%0d layer=%0d row=%0d",
                   cyc, got[91:80], got.epoch_count, got.wl, got.wr, e[91:80], e.epoch_count, e.wl, e.wr);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: bench did not finish, got running, expected finish");
    $fatal(1);
  end

  initial begin : driver
    logic [3:0]  o;
    logic [31:0] li;
    int          sel;
    cur = idle_e(1'b1);
    tick(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 16'd0);
    tick(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 16'd0);
    if (op_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after reset: got op_ready=%b busy=%b, expected op_ready=1 busy=0", op_ready, busy);
    end
    tick(1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 16'd0);
    run_op(4'd1, 32'd0, 16'd2, 0, 0, 0, 1'b0);
    run_op(4'd1, 32'd2, 16'd2, 0, 0, 0, 1'b0);
    run_op(4'd2, 32'd2, 16'd2, 0, 0, 0, 1'b0);
    run_op(4'd1, 32'd0, 16'd2, 5, 6, 0, 1'b0);
    repeat (3) run_op(4'd3, 32'd0, 16'd2, 0, 0, 0, 1'b0);
    run_op(4'd2, 32'd4, 16'd2, 0, 0, 0, 1'b0);
    run_op(4'd1, 32'd1, 16'd2, 0, 0, 6, 1'b0);
    run_op(4'd2, 32'd0, 16'd2, 0, 0, 0, 1'b0);
    run_op(4'd2, 32'd3, 16'd2, 0, 0, 0, 1'b0);
    run_op(4'd0, 32'd1, 16'd2, 0, 0, 0, 1'b0);
    run_op(4'd9, 32'd1, 16'd2, 0, 0, 0, 1'b0);
    run_op(4'd1, 32'hFFFF_FFFF, 16'd2, 0, 0, 0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 4'd1, 32'd0, 16'd2);
    tick(1'b0, 1'b0, 1'b1, 4'd1, 32'd0, 16'd2);
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)       o = 4'd1;
      else if (sel < 7)  o = 4'd2;
      else if (sel == 7) o = 4'd3;
      else if (sel == 8) o = 4'd0;
      else               o = 4'($urandom_range(4, 15));
      li = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, MAXL - 1));
      run_op(o, li, 16'($urandom_range(0, 3)), 0, 0, 0, ($urandom_range(0, 2) == 0));
      repeat ($urandom_range(0, 2)) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'd0, 32'd0, 16'd0);
    end
    tick(1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 16'd0);
    @(negedge clk); #1;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", expq.size());
    end
    if (n_tests < 12) begin
      n_fail++;
      $display("FAIL coverage: got %0d compared cycles, expected at least 12", n_tests);
    end
    if (n_fail != 0)
      $display("FAIL summary: %0d mismatches", n_fail);
    else
      $display("PASS");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
